// File: rtl/key_entry_ctrl.sv
// Keypad entry controller: handshakes keys from a scanner and assembles two signed operands plus an operator.
// Optional display output enabled by defining KEY_ENTRY_DISPLAY_EN.
module key_entry_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        read_input,
   input  logic [3:0]  keypad_input,
   input  logic [2:0]  operator_input,
   input  logic        equal_input,
   output logic        key_read,
   output logic [15:0] operand_a,
   output logic [15:0] operand_b,
   output logic [2:0]  op_code,
   output logic        calc_valid,
   output logic        entry_overflow
`ifdef KEY_ENTRY_DISPLAY_EN
   ,
   output logic [15:0] display_value
`endif
);

   localparam logic [2:0] OP_NEG = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;

   typedef enum logic {HS_IDLE, HS_ACK}     hs_t;
   typedef enum logic {ENTRY_A, ENTRY_B}    entry_t;

   hs_t         hs_q;
   entry_t      entry_q;
   logic        key_read_q, calc_valid_q, eq_pend_q, ovf_q;
   logic [14:0] mag_a_q, mag_b_q;
   logic        neg_a_q, neg_b_q;
   logic [2:0]  op_code_q;

   logic [14:0] cur_mag;
   logic [19:0] mag_d;
   logic        digit_ok, digit_fits, take_key;

   // Wide enough for 32767*10+9 so the overflow compare never wraps.
   always_comb begin
      cur_mag    = (entry_q == ENTRY_A) ? mag_a_q : mag_b_q;
      mag_d      = {5'b0, cur_mag} * 20'd10 + {16'b0, keypad_input};
      digit_ok   = (keypad_input <= 4'd9);
      digit_fits = (mag_d <= 20'd32767);
      // Keys wait in the scanner while a result is being presented.
      take_key   = (hs_q == HS_IDLE) && read_input && !eq_pend_q && !calc_valid_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_q         <= HS_IDLE;
         entry_q      <= ENTRY_A;
         key_read_q   <= 1'b0;
         calc_valid_q <= 1'b0;
         eq_pend_q    <= 1'b0;
         ovf_q        <= 1'b0;
         mag_a_q      <= '0;
         mag_b_q      <= '0;
         neg_a_q      <= 1'b0;
         neg_b_q      <= 1'b0;
         op_code_q    <= 3'b000;
      end else begin
         if (calc_valid_q) begin
            calc_valid_q <= 1'b0;
            entry_q      <= ENTRY_A;
            ovf_q        <= 1'b0;
            mag_a_q      <= '0;
            mag_b_q      <= '0;
            neg_a_q      <= 1'b0;
            neg_b_q      <= 1'b0;
            op_code_q    <= 3'b000;
         end else if (eq_pend_q) begin
            calc_valid_q <= 1'b1;
            eq_pend_q    <= 1'b0;
         end

         case (hs_q)
            HS_IDLE: begin
               if (take_key) begin
                  key_read_q <= 1'b1;
                  hs_q       <= HS_ACK;
                  if (equal_input) begin
                     if (entry_q == ENTRY_B) eq_pend_q <= 1'b1;
                  end else if (operator_input != 3'b000) begin
                     case (operator_input)
                        OP_NEG: begin
                           if (entry_q == ENTRY_A) neg_a_q <= ~neg_a_q;
                           else                    neg_b_q <= ~neg_b_q;
                        end
                        OP_ADD, OP_SUB, OP_MUL: begin
                           op_code_q <= operator_input;
                           entry_q   <= ENTRY_B;
                        end
                        default: ;
                     endcase
                  end else if (digit_ok) begin
                     if (!digit_fits)              ovf_q   <= 1'b1;
                     else if (entry_q == ENTRY_A)  mag_a_q <= mag_d[14:0];
                     else                          mag_b_q <= mag_d[14:0];
                  end
               end
            end
            HS_ACK: begin
               if (!read_input) begin
                  key_read_q <= 1'b0;
                  hs_q       <= HS_IDLE;
               end
            end
            default: hs_q <= HS_IDLE;
         endcase
      end
   end

   assign key_read       = key_read_q;
   assign calc_valid     = calc_valid_q;
   assign entry_overflow = ovf_q;
   assign op_code        = op_code_q;
   assign operand_a      = neg_a_q ? (16'd0 - {1'b0, mag_a_q}) : {1'b0, mag_a_q};
   assign operand_b      = neg_b_q ? (16'd0 - {1'b0, mag_b_q}) : {1'b0, mag_b_q};

`ifdef KEY_ENTRY_DISPLAY_EN
   assign display_value  = (entry_q == ENTRY_B) ? operand_b : operand_a;
`endif

endmodule
